// File: rtl/core_mem_arbiter_if.sv
// Bus bundle between the core's fetch/data request ports, the arbiter and
// the memory port.
//   i_req_*/i_ack_rdata : instruction-fetch request and response
//   d_req_*/d_ack_rdata : data request and response
//   m_req_*/m_ack_rdata : shared memory request and response
//   to_err              : sticky memory watchdog error
// Modports:
//   slave  - the arbiter's view (serves the core ports, drives the memory port)
//   master - the environment's view (core requesters plus memory model)
interface core_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int COP_W  = 3,
  parameter int SIZE_W = 3
);
  logic              i_req_val;
  logic [ADDR_W-1:0] i_req_addr;
  logic              i_req_ack;
  logic [DATA_W-1:0] i_ack_rdata;

  logic              d_req_val;
  logic [ADDR_W-1:0] d_req_addr;
  logic [COP_W-1:0]  d_req_cop;
  logic [DATA_W-1:0] d_req_wdata;
  logic [SIZE_W-1:0] d_req_size;
  logic              d_req_ack;
  logic [DATA_W-1:0] d_ack_rdata;

  logic              m_req_val;
  logic [ADDR_W-1:0] m_req_addr;
  logic [COP_W-1:0]  m_req_cop;
  logic [DATA_W-1:0] m_req_wdata;
  logic [SIZE_W-1:0] m_req_size;
  logic              m_req_ack;
  logic [DATA_W-1:0] m_ack_rdata;

  logic              to_err;

  modport slave (
    input  i_req_val, i_req_addr,
    output i_req_ack, i_ack_rdata,
    input  d_req_val, d_req_addr, d_req_cop, d_req_wdata, d_req_size,
    output d_req_ack, d_ack_rdata,
    output m_req_val, m_req_addr, m_req_cop, m_req_wdata, m_req_size,
    input  m_req_ack, m_ack_rdata,
    output to_err
  );

  modport master (
    output i_req_val, i_req_addr,
    input  i_req_ack, i_ack_rdata,
    output d_req_val, d_req_addr, d_req_cop, d_req_wdata, d_req_size,
    input  d_req_ack, d_ack_rdata,
    input  m_req_val, m_req_addr, m_req_cop, m_req_wdata, m_req_size,
    output m_req_ack, m_ack_rdata,
    input  to_err
  );
endinterface

// File: rtl/core_mem_arbiter.sv
// Shares one memory port between the core's instruction-fetch (i) and data
// (d) request ports. One transaction outstanding at a time, round-robin on
// conflicts, and a watchdog that flags a memory that never acknowledges.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - core_mem_arbiter_if.slave: i/d request ports, memory port, to_err
// Parameters:
//   ADDR_W/DATA_W/COP_W/SIZE_W - bus widths (must match the interface)
//   TIMEOUT - BUSY cycles without m_req_ack before to_err sets; 0 disables
module core_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int COP_W   = 3,
  parameter int SIZE_W  = 3,
  parameter int TIMEOUT = 256
) (
  input logic                clk,
  input logic                rst_n,
  core_mem_arbiter_if.slave  bus
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
  typedef enum logic {GNT_I, GNT_D} gnt_t;

  state_t state, state_next;
  gnt_t   last_gnt;
  logic   launch_i, launch_d;
  logic   busy;

  logic              val_q;
  logic [ADDR_W-1:0] addr_q;
  logic [COP_W-1:0]  cop_q;
  logic [DATA_W-1:0] wdata_q;
  logic [SIZE_W-1:0] size_q;

  logic [CNT_W-1:0]  wd_cnt;
  logic              err_q;

  assign busy = (state != IDLE);

  // Arbitration: a lone requester wins; on a conflict the side opposite
  // last_gnt wins. Requester inputs only matter in IDLE.
  always_comb begin
    state_next = state;
    launch_i   = 1'b0;
    launch_d   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.i_req_val && (!bus.d_req_val || last_gnt == GNT_D)) begin
          launch_i   = 1'b1;
          state_next = BUSY_I;
        end else if (bus.d_req_val) begin
          launch_d   = 1'b1;
          state_next = BUSY_D;
        end
      end
      BUSY_I, BUSY_D: begin
        if (bus.m_req_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q    <= 1'b0;
      addr_q   <= '0;
      cop_q    <= '0;
      wdata_q  <= '0;
      size_q   <= '0;
      last_gnt <= GNT_D;
    end else if (launch_i) begin
      // Fetches are always 4-byte reads.
      val_q    <= 1'b1;
      addr_q   <= bus.i_req_addr;
      cop_q    <= '0;
      wdata_q  <= '0;
      size_q   <= SIZE_W'(4);
      last_gnt <= GNT_I;
    end else if (launch_d) begin
      val_q    <= 1'b1;
      addr_q   <= bus.d_req_addr;
      cop_q    <= bus.d_req_cop;
      wdata_q  <= bus.d_req_wdata;
      size_q   <= bus.d_req_size;
      last_gnt <= GNT_D;
    end else if (busy && bus.m_req_ack) begin
      val_q    <= 1'b0;
    end
  end

  // Watchdog: to_err sets on the same edge the count reaches TIMEOUT, so it
  // is visible in the first cycle after TIMEOUT unacknowledged BUSY cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (launch_i || launch_d) begin
        wd_cnt <= '0;
      end else if (busy && !bus.m_req_ack && wd_cnt != CNT_MAX) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
      if (TIMEOUT != 0 && busy && !bus.m_req_ack && wd_cnt == CNT_LAST) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.m_req_val   = val_q;
  assign bus.m_req_addr  = addr_q;
  assign bus.m_req_cop   = cop_q;
  assign bus.m_req_wdata = wdata_q;
  assign bus.m_req_size  = size_q;
  assign bus.to_err      = err_q;

  assign bus.i_req_ack   = (state == BUSY_I) && bus.m_req_ack;
  assign bus.d_req_ack   = (state == BUSY_D) && bus.m_req_ack;
  assign bus.i_ack_rdata = (state == BUSY_I) ? bus.m_ack_rdata : '0;
  assign bus.d_ack_rdata = (state == BUSY_D) ? bus.m_ack_rdata : '0;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Self-checking bench for core_mem_arbiter: directed vector table, stray-ack,
// randomized round-robin traffic against a transaction-level model, watchdog
// and reset-mid-transaction sequences.
module tb_core_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 3;
  localparam int SW = 3;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  core_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .COP_W(CW), .SIZE_W(SW)) bus ();

  core_mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .COP_W(CW), .SIZE_W(SW), .TIMEOUT(TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int fails  = 0;

  // Model state: winner of the last grant (1 = I) and expected sticky error.
  logic last_i = 1'b0;
  logic exp_to_err = 1'b0;

  typedef struct {
    logic        iv;
    logic        dv;
    logic [31:0] ia;
    logic [31:0] da;
    logic [2:0]  cop;
    logic [31:0] wd;
    logic [2:0]  sz;
    int          lat;
    logic [31:0] rd;
    logic        exp_i;
  } vec_t;

  vec_t vecs [8];

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Runs one transaction starting in an IDLE cycle. Expected memory fields
  // follow from which side wins: fetch = read, size 4, wdata 0.
  task automatic run_txn(input logic iv, input logic dv,
                         input logic [31:0] ia, input logic [31:0] da,
                         input logic [2:0] dcop, input logic [31:0] dwd,
                         input logic [2:0] dsz, input int lat,
                         input logic [31:0] rd, input logic win_i);
    logic [31:0] e_addr, e_wd;
    logic [2:0]  e_cop, e_sz;
    e_addr = win_i ? ia : da;
    e_cop  = win_i ? 3'd0 : dcop;
    e_wd   = win_i ? 32'd0 : dwd;
    e_sz   = win_i ? 3'd4 : dsz;
    bus.i_req_val   = iv;
    bus.i_req_addr  = ia;
    bus.d_req_val   = dv;
    bus.d_req_addr  = da;
    bus.d_req_cop   = dcop;
    bus.d_req_wdata = dwd;
    bus.d_req_size  = dsz;
    bus.m_req_ack   = 1'b0;
    settle();
    chk1("idle_gap_val", bus.m_req_val, 1'b0);
    tick();
    for (int c = 0; c <= lat; c++) begin
      if (c == lat) begin
        bus.m_req_ack   = 1'b1;
        bus.m_ack_rdata = rd;
        if (win_i) bus.i_req_val = 1'b0;
        else       bus.d_req_val = 1'b0;
      end else begin
        // Inputs are ignored while busy: wiggle the winner's fields.
        if (win_i) bus.i_req_addr = $urandom;
        else begin
          bus.d_req_addr  = $urandom;
          bus.d_req_wdata = $urandom;
        end
        bus.m_ack_rdata = $urandom;
      end
      settle();
      chk1("busy_val", bus.m_req_val, 1'b1);
      chk32("m_addr", bus.m_req_addr, e_addr);
      chk32("m_cop", 32'(bus.m_req_cop), 32'(e_cop));
      chk32("m_wdata", bus.m_req_wdata, e_wd);
      chk32("m_size", 32'(bus.m_req_size), 32'(e_sz));
      chk1("to_err", bus.to_err, exp_to_err);
      if (c == lat) begin
        chk1("i_ack", bus.i_req_ack, win_i);
        chk1("d_ack", bus.d_req_ack, !win_i);
        chk32("ack_rdata", win_i ? bus.i_ack_rdata : bus.d_ack_rdata, rd);
      end else begin
        chk1("i_ack_early", bus.i_req_ack, 1'b0);
        chk1("d_ack_early", bus.d_req_ack, 1'b0);
      end
      tick();
    end
    bus.m_req_ack = 1'b0;
  endtask

  // An IDLE cycle with no requesters, optionally with a stray memory ack.
  task automatic idle_cycle(input logic stray);
    bus.i_req_val   = 1'b0;
    bus.d_req_val   = 1'b0;
    bus.m_req_ack   = stray;
    bus.m_ack_rdata = $urandom;
    settle();
    chk1("stray_i_ack", bus.i_req_ack, 1'b0);
    chk1("stray_d_ack", bus.d_req_ack, 1'b0);
    chk1("stray_val", bus.m_req_val, 1'b0);
    tick();
    bus.m_req_ack = 1'b0;
  endtask

  initial begin
    logic        pend_i, pend_d, exp_i;
    logic [31:0] pia, pda, pwd;
    logic [2:0]  pcop, psz;

    vecs[0] = '{1'b1, 1'b0, 32'h100, 32'h0,   3'd0, 32'h0,    3'd0, 3, 32'hDEADBEEF, 1'b1};
    vecs[1] = '{1'b0, 1'b1, 32'h0,   32'h20,  3'd1, 32'h55AA, 3'd2, 2, 32'h0,        1'b0};
    vecs[2] = '{1'b1, 1'b1, 32'h200, 32'h300, 3'd0, 32'h1111, 3'd4, 1, 32'hA0,       1'b1};
    vecs[3] = '{1'b1, 1'b1, 32'h200, 32'h300, 3'd0, 32'h1111, 3'd4, 0, 32'hA1,       1'b0};
    vecs[4] = '{1'b1, 1'b1, 32'h204, 32'h304, 3'd1, 32'h2222, 3'd1, 4, 32'hA2,       1'b1};
    vecs[5] = '{1'b1, 1'b1, 32'h208, 32'h304, 3'd1, 32'h2222, 3'd1, 2, 32'hA3,       1'b0};
    vecs[6] = '{1'b0, 1'b1, 32'h0,   32'h40,  3'd2, 32'h3333, 3'd1, 5, 32'hA4,       1'b0};
    vecs[7] = '{1'b1, 1'b0, 32'h20C, 32'h0,   3'd0, 32'h0,    3'd0, 0, 32'hA5,       1'b1};

    bus.i_req_val = 1'b0; bus.i_req_addr = '0;
    bus.d_req_val = 1'b0; bus.d_req_addr = '0; bus.d_req_cop = '0;
    bus.d_req_wdata = '0; bus.d_req_size = '0;
    bus.m_req_ack = 1'b1; bus.m_ack_rdata = 32'hFFFF_FFFF;

    // Reset state, with a memory ack present that must not leak through.
    #12;
    chk1("rst_m_val", bus.m_req_val, 1'b0);
    chk32("rst_m_addr", bus.m_req_addr, 32'd0);
    chk32("rst_m_wdata", bus.m_req_wdata, 32'd0);
    chk32("rst_m_cop", 32'(bus.m_req_cop), 32'd0);
    chk32("rst_m_size", 32'(bus.m_req_size), 32'd0);
    chk1("rst_to_err", bus.to_err, 1'b0);
    chk1("rst_i_ack", bus.i_req_ack, 1'b0);
    chk1("rst_d_ack", bus.d_req_ack, 1'b0);
    bus.m_req_ack = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    for (int v = 0; v < 8; v++) begin
      run_txn(vecs[v].iv, vecs[v].dv, vecs[v].ia, vecs[v].da, vecs[v].cop,
              vecs[v].wd, vecs[v].sz, vecs[v].lat, vecs[v].rd, vecs[v].exp_i);
      last_i = vecs[v].exp_i;
    end

    idle_cycle(1'b1);
    idle_cycle(1'b1);

    // Randomized traffic: pending requests per side; a loser stays pending.
    pend_i = 1'b0; pend_d = 1'b0;
    pia = '0; pda = '0; pwd = '0; pcop = '0; psz = '0;
    for (int n = 0; n < 60; n++) begin
      if (!pend_i && $urandom_range(1, 0) == 1) begin
        pend_i = 1'b1; pia = $urandom;
      end
      if (!pend_d && $urandom_range(1, 0) == 1) begin
        pend_d = 1'b1; pda = $urandom; pwd = $urandom;
        pcop = 3'($urandom_range(7, 0)); psz = 3'($urandom_range(7, 0));
      end
      if (!pend_i && !pend_d) begin
        idle_cycle(1'($urandom_range(1, 0)));
        pend_i = 1'b1; pia = $urandom;
      end
      exp_i = pend_i && (!pend_d || !last_i);
      run_txn(pend_i, pend_d, pia, pda, pcop, pwd, psz,
              int'($urandom_range(5, 0)), $urandom, exp_i);
      last_i = exp_i;
      if (exp_i) pend_i = 1'b0;
      else       pend_d = 1'b0;
    end
    if (pend_d) begin
      run_txn(1'b0, 1'b1, 32'h0, pda, pcop, pwd, psz, 1, 32'h5, 1'b0);
      last_i = 1'b0;
    end

    // Watchdog: memory silent for 20 BUSY cycles, then a late ack.
    bus.i_req_val = 1'b0;
    bus.d_req_val = 1'b1; bus.d_req_addr = 32'h80; bus.d_req_cop = 3'd0;
    bus.d_req_wdata = 32'h0; bus.d_req_size = 3'd4;
    settle();
    chk1("wd_idle_val", bus.m_req_val, 1'b0);
    tick();
    for (int b = 1; b <= 20; b++) begin
      settle();
      chk1("wd_val", bus.m_req_val, 1'b1);
      chk1("wd_to_err", bus.to_err, (b >= 9) ? 1'b1 : 1'b0);
      tick();
    end
    bus.m_req_ack = 1'b1; bus.m_ack_rdata = 32'hCAFE_0001; bus.d_req_val = 1'b0;
    settle();
    chk1("wd_late_ack", bus.d_req_ack, 1'b1);
    chk32("wd_late_rdata", bus.d_ack_rdata, 32'hCAFE_0001);
    chk1("wd_err_held", bus.to_err, 1'b1);
    tick();
    bus.m_req_ack = 1'b0;
    last_i = 1'b0;
    exp_to_err = 1'b1;
    run_txn(1'b1, 1'b0, 32'h400, 32'h0, 3'd0, 32'h0, 3'd0, 1, 32'h77, 1'b1);
    last_i = 1'b1;

    // Reset while a data transaction is in flight.
    bus.d_req_val = 1'b1; bus.d_req_addr = 32'h90; bus.d_req_cop = 3'd1;
    bus.d_req_wdata = 32'h1234; bus.d_req_size = 3'd2;
    tick();
    settle();
    chk1("mid_busy_val", bus.m_req_val, 1'b1);
    rst_n = 1'b0;
    bus.m_req_ack = 1'b1;
    #1;
    chk1("mid_rst_val", bus.m_req_val, 1'b0);
    chk1("mid_rst_to_err", bus.to_err, 1'b0);
    chk32("mid_rst_addr", bus.m_req_addr, 32'd0);
    chk1("mid_rst_d_ack", bus.d_req_ack, 1'b0);
    tick();
    tick();
    bus.m_req_ack = 1'b0;
    bus.d_req_val = 1'b0;
    rst_n = 1'b1;
    last_i = 1'b0;
    exp_to_err = 1'b0;
    tick();
    run_txn(1'b1, 1'b1, 32'h500, 32'h600, 3'd1, 32'h99, 3'd2, 2, 32'hBEEF, 1'b1);
    run_txn(1'b1, 1'b1, 32'h504, 32'h600, 3'd1, 32'h99, 3'd2, 1, 32'hBEF0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end
endmodule
